axi_lite_regbank: RTL

Parametrised AXI4-Lite slave register bank. It generalises the fixed 4 x 32-bit peripheral register interface to N registers of configurable width. Adds byte strobes, per-register read-only status inputs, SLVERR decoding and per-register write-strobe pulses. It sits behind the AXI interconnect as the control/status port of each custom coprocessor core.

---
 rtl/axi_lite_regbank_if.sv | 55 +++++
 rtl/axi_lite_regbank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank_if.sv
// AXI4-Lite bus bundle for axi_lite_regbank.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R). The clock and reset
// are not part of the bundle.
//   slave  modport : the register bank side (drives the READY/VALID responses)
//   master modport : the interconnect/initiator side
interface axi_lite_regbank_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// Parametrised AXI4-Lite slave register bank (control/status port).
// Ports:
//   ACLK      - clock, rising edge
//   ARESET    - synchronous active-high reset
//   s_axi     - AXI4-Lite slave bus (axi_lite_regbank_if.slave)
//   regs_out  - current register contents, reg i in slice i
//   status_in - status values returned when reading read-only registers
//   wr_pulse  - one-cycle pulse per register after a committed write
// Out-of-range or read-only write targets answer SLVERR without updating;
// out-of-range reads return 0 with SLVERR.
module axi_lite_regbank #(
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    ADDR_WIDTH = 6,
  parameter int unsigned                    NUM_REGS   = 4,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALS = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axi_lite_regbank_if.slave              s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  // A single register still gets a 1-bit index; index 1 then decodes as out-of-range.
  localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]       w_strb_q, w_strb_d;
  logic                    awready_q, awready_d, wready_q, wready_d;
  logic                    bvalid_q, bvalid_d, arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic                    aw_hs, w_hs, ar_hs, commit, c_wr;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [DATA_WIDTH-1:0]   c_data;
  logic [STRB_W-1:0]       c_strb;
  logic [IDX_W-1:0]        c_idx, r_idx;

  // Any address bit above the index field makes the access out-of-range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    logic [IDX_W-1:0]      idx;
    hi  = a >> (ADDR_LSB + IDX_W);
    idx = a[ADDR_LSB +: IDX_W];
    return (hi == '0) && (32'(idx) < NUM_REGS);
  endfunction

  // Write channel
  always_comb begin
    w_state_d  = w_state_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    wr_pulse_d = '0;
    commit     = 1'b0;
    c_wr       = 1'b0;
    c_addr     = s_axi.S_AXI_AWADDR;
    c_data     = s_axi.S_AXI_WDATA;
    c_strb     = s_axi.S_AXI_WSTRB;
    aw_hs      = s_axi.S_AXI_AWVALID && awready_q;
    w_hs       = s_axi.S_AXI_WVALID && wready_q;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          aw_addr_d = s_axi.S_AXI_AWADDR;
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_data_d  = s_axi.S_AXI_WDATA;
          w_strb_d  = s_axi.S_AXI_WSTRB;
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        commit = 1'b1;
        c_addr = aw_addr_q;
      end
      W_HAVE_DATA: if (aw_hs) begin
        commit = 1'b1;
        c_data = w_data_q;
        c_strb = w_strb_q;
      end
      W_RESP: if (s_axi.S_AXI_BREADY) begin
        bvalid_d  = 1'b0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    c_idx = c_addr[ADDR_LSB +: IDX_W];
    if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (in_range(c_addr) && c_idx == IDX_W'(i) && !RO_MASK[i]) begin
          c_wr          = 1'b1;
          wr_pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (c_strb[b]) regs_d[i][8*b +: 8] = c_data[8*b +: 8];
          end
        end
      end
      bresp_d   = c_wr ? RESP_OKAY : RESP_SLVERR;
      bvalid_d  = 1'b1;
      w_state_d = W_RESP;
    end

    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
  end

  // Read channel; samples regs_q so a same-edge write is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
    r_idx     = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];

    unique case (r_state_q)
      R_IDLE: if (ar_hs) begin
        r_state_d = R_DATA;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rdata_d   = '0;
        rresp_d   = RESP_SLVERR;
        if (in_range(s_axi.S_AXI_ARADDR)) begin
          rresp_d = RESP_OKAY;
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == IDX_W'(i)) begin
              rdata_d = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
          end
        end
      end
      R_DATA: if (s_axi.S_AXI_RREADY) begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      arready_q  <= 1'b1;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      bresp_q    <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      bvalid_q   <= bvalid_d;
      rvalid_q   <= rvalid_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign wr_pulse            = wr_pulse_q;

  // PROT is ignored; status_in of read/write registers is never read.
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, status_in,
                       s_axi.S_AXI_AWADDR, s_axi.S_AXI_ARADDR};
endmodule
